andornot_sweep_ctrl: RTL and testbench
======================================

Name: andornot_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 4-input AndOrNot gate in hardware. It drives all 16 input combinations onto a, b, c, d and waits a programmable settle time. It then samples y into a 16-bit truth-table register and compares each sample against a caller-supplied expected table. It sits between a start/done control interface (board switches or a higher-level test FSM) and one AndOrNot instance.

Parameters:
SETTLE_CYCLES, 2, extra wait cycles after a new vector is driven before y is sampled (0 legal; max 15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  terminate sweep; sampled only while busy
expected  input  16  expected y per vector; bit i = y for vector i; latched on accepted start
y  input  1  output of the AndOrNot instance
a  output  1  vector bit 3 (MSB)
b  output  1  vector bit 2
c  output  1  vector bit 1
d  output  1  vector bit 0 (LSB)
busy  output  1  high from the cycle after accepted start until the last SAMPLE completes
done  output  1  one-cycle pulse when a full sweep completes
truth_table  output  16  captured y; bit i = y sampled for vector i
mismatch_count  output  5  number of vectors where y != expected bit (0..16)
match  output  1  1 when last completed sweep had mismatch_count == 0

Behaviour:
- Reset (synchronous, active-high): state=IDLE; a=b=c=d=0; busy=0; done=0; truth_table=0; mismatch_count=0; match=0; idx=0; settle counter=0. Reset overrides start/abort in the same cycle.
- {a,b,c,d} is always the registered idx. It is 0 in IDLE and DONE.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: done=0. When start=1: latch expected; clear truth_table and mismatch_count; idx=0; cnt=SETTLE_CYCLES; set busy=1; go to WAIT.
- WAIT: if cnt==0, go to SAMPLE; else cnt=cnt-1. WAIT lasts SETTLE_CYCLES+1 cycles.
- SAMPLE, same edge:
  - truth_table[idx] <= y.
  - If y != expected_latched[idx], mismatch_count += 1.
  - If idx==15, go to DONE.
  - Otherwise idx += 1, cnt=SETTLE_CYCLES, go to WAIT.
- DONE (one cycle):
  - done=1, busy=0, idx=0.
  - match = (final mismatch_count == 0); this must include the last SAMPLE's update.
  - Next state: IDLE.
- Per-vector time is SETTLE_CYCLES+2 cycles. Counting from the edge that accepts start (edge k), done is high in the cycle after edge k+1+16*(SETTLE_CYCLES+2). With the default of 2, done is high after edge k+65.
- start while busy or in DONE: ignored, with no restart.
- abort in WAIT or SAMPLE:
  - Takes effect at the next edge: state=IDLE, busy=0, idx=0, no done pulse.
  - If abort and the final SAMPLE coincide, abort wins and there is no done pulse.
  - truth_table and mismatch_count keep their partial contents; match is unchanged. In SAMPLE, that cycle's truth_table write still occurs.
- abort in IDLE or DONE: ignored.
- truth_table, mismatch_count and match hold their values after done until the next accepted start or reset.
- idx is 4 bits. The advance is guarded at 15, so it never wraps.
- mismatch_count is 5 bits, so 16 mismatches (10000b) is representable.

Test Plan:
- Bench models y = a&b; expected=16'hF000; start pulse; SETTLE=2 -> truth_table=16'hF000, mismatch_count=0, match=1, done pulse exactly 65 cycles after the start edge, busy high for 64 cycles.
- Bench ties y=0; expected=16'h00FF -> truth_table=16'h0000, mismatch_count=8, match=0. Then y=1 with expected=16'h0000 -> mismatch_count=16, match=0.
- Monitor a,b,c,d during a sweep -> values 0..15 in order, each held 4 cycles (SETTLE=2). The y sample is taken in the last cycle of each hold. All four are 0 after done.
- start asserted at random cycles during a busy sweep -> no restart, and done timing is unchanged. Then assert abort at vector 7 -> busy=0 next cycle, no done pulse, truth_table bits 7..0 written and bits 15..8 hold their cleared value of 0.
- reset asserted mid-sweep (vector 10) -> next cycle all outputs are 0 and the state is IDLE. A new start then completes a normal sweep.
- Re-elaborate with SETTLE_CYCLES=0, y=~d, expected=16'h5555 -> done 33 cycles after the start edge, truth_table=16'h5555, match=1.

Source files
------------

// File: rtl/andornot_sweep_ctrl.sv
// rtl/andornot_sweep_ctrl.sv - sequencer that sweeps all 16 AndOrNot input vectors
// Drives {a,b,c,d}, waits SETTLE_CYCLES, captures y into a truth table and scores it against an expected table.
module andornot_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_count,
  output logic        match
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mc_q, mc_d;
  logic        match_q, match_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mc_d    = mc_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = expected;
          tt_d    = 16'h0000;
          mc_d    = 5'd0;
          idx_d   = 4'd0;
          cnt_d   = SETTLE_INIT;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          idx_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        // The capture and score happen even when abort lands on this cycle.
        tt_d[idx_q] = y;
        if (y != exp_q[idx_q]) begin
          mc_d = mc_q + 5'd1;
        end
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          idx_d   = 4'd0;
        end else if (idx_q == 4'd15) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          idx_d   = 4'd0;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = SETTLE_INIT;
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        match_d = (mc_q == 5'd0);
        idx_d   = 4'd0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 16'h0000;
      tt_q    <= 16'h0000;
      mc_q    <= 5'd0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mc_q    <= mc_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a              = idx_q[3];
  assign b              = idx_q[2];
  assign c              = idx_q[1];
  assign d              = idx_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign truth_table    = tt_q;
  assign mismatch_count = mc_q;
  assign match          = match_q;

endmodule

// File: tb/tb_andornot_sweep_ctrl.sv
// tb/tb_andornot_sweep_ctrl.sv - directed self-checking bench for andornot_sweep_ctrl
// Two instances: default settle time, and zero settle time driven by y = ~d.
module tb_andornot_sweep_ctrl;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [15:0] expected;
  logic y;
  logic a, b, c, d, busy, done, match;
  logic [15:0] truth_table;
  logic [4:0] mismatch_count;

  logic start1;
  logic [15:0] expected1;
  logic y1;
  logic a1, b1, c1, d1, busy1, done1, match1;
  logic [15:0] truth_table1;
  logic [4:0] mismatch_count1;

  int y_mode;
  int n_checks = 0;
  int n_fail = 0;
  int busy_cycles, done_n, done_cnt, abcd_errs;

  always #5 clk = ~clk;

  always_comb begin
    case (y_mode)
      0:       y = a & b;
      1:       y = 1'b0;
      2:       y = 1'b1;
      default: y = ~d;
    endcase
  end

  assign y1 = ~d1;

  andornot_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(expected), .y(y),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .truth_table(truth_table),
    .mismatch_count(mismatch_count), .match(match)
  );

  andornot_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .expected(expected1), .y(y1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .truth_table(truth_table1),
    .mismatch_count(mismatch_count1), .match(match1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // n counts edges after the accepting edge k; outputs are observed 1 time unit after each edge.
  task automatic sweep(input int mode, input logic [15:0] exp_v, input int abort_n, input bit spam);
    y_mode = mode;
    @(posedge clk); #1;
    expected = exp_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles = 0; done_n = -1; done_cnt = 0; abcd_errs = 0;
    for (int n = 0; n < 72; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      abort = (n == abort_n);
      start = spam && (n < 64) && (n % 7 == 3);
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (abort_n < 0 && {a, b, c, d} != ((n < 64) ? 4'(n / 4) : 4'd0)) abcd_errs++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; expected = 16'h0;
    start1 = 1'b0; expected1 = 16'h0; y_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tt", 32'(truth_table), 32'h0);
    check("rst_mc", 32'(mismatch_count), 32'h0);
    check("rst_flags", {29'd0, busy, done, match}, 32'h0);
    check("rst_abcd", {28'd0, a, b, c, d}, 32'h0);
    reset = 1'b0;

    sweep(0, 16'hF000, -1, 1'b0);
    check("and_tt", 32'(truth_table), 32'hF000);
    check("and_mc", 32'(mismatch_count), 32'd0);
    check("and_match", 32'(match), 32'd1);
    check("and_done_n", done_n, 32'd65);
    check("and_done_cnt", done_cnt, 32'd1);
    check("and_busy", busy_cycles, 32'd64);
    check("and_abcd_seq", abcd_errs, 32'd0);

    sweep(1, 16'h00FF, -1, 1'b0);
    check("zero_tt", 32'(truth_table), 32'h0000);
    check("zero_mc", 32'(mismatch_count), 32'd8);
    check("zero_match", 32'(match), 32'd0);

    sweep(2, 16'h0000, -1, 1'b0);
    check("one_tt", 32'(truth_table), 32'hFFFF);
    check("one_mc", 32'(mismatch_count), 32'd16);
    check("one_match", 32'(match), 32'd0);

    sweep(0, 16'hF000, -1, 1'b1);
    check("spam_done_n", done_n, 32'd65);
    check("spam_done_cnt", done_cnt, 32'd1);
    check("spam_match", 32'(match), 32'd1);

    // Abort raised in the SAMPLE cycle of vector 7: bits 7..0 captured.
    sweep(2, 16'h0000, 31, 1'b0);
    check("abort_busy", busy_cycles, 32'd32);
    check("abort_done_cnt", done_cnt, 32'd0);
    check("abort_tt", 32'(truth_table), 32'h00FF);
    check("abort_mc", 32'(mismatch_count), 32'd8);
    check("abort_match", 32'(match), 32'd1);
    check("abort_abcd", {28'd0, a, b, c, d}, 32'h0);

    y_mode = 2;
    @(posedge clk); #1;
    expected = 16'h0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("pre_rst_abcd", {28'd0, a, b, c, d}, 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_tt", 32'(truth_table), 32'h0);
    check("mid_rst_mc", 32'(mismatch_count), 32'h0);
    check("mid_rst_flags", {28'd0, busy, done, match, 1'b0}, 32'h0);
    check("mid_rst_abcd", {28'd0, a, b, c, d}, 32'h0);

    sweep(0, 16'hF000, -1, 1'b0);
    check("post_rst_tt", 32'(truth_table), 32'hF000);
    check("post_rst_match", 32'(match), 32'd1);
    check("post_rst_done_n", done_n, 32'd65);

    @(posedge clk); #1;
    expected1 = 16'h5555;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    done_n = -1;
    for (int n = 0; n < 50; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (done1 && done_n < 0) done_n = n;
    end
    check("s0_done_n", done_n, 32'd33);
    check("s0_tt", 32'(truth_table1), 32'h5555);
    check("s0_match", 32'(match1), 32'd1);
    check("s0_mc", 32'(mismatch_count1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
